mux2_rr_arbiter: RTL and testbench
==================================

MUX2_RR_ARBITER -- requirements
Module: mux2_rr_arbiter

Interface
REQ-001 Parameter W, default 8: data width of each requester and of the output.
REQ-002 Parameter TIMEOUT, default 16: consecutive idle-beat limit used only when MUX2_RR_ARBITER_TIMEOUT_EN is defined.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 a_valid, a_last  in  1 each; a_data  in  W;  a_ready  out  1: requester A.
REQ-006 b_valid, b_last  in  1 each; b_data  in  W;  b_ready  out  1: requester B.
REQ-007 y_valid, y_last  out  1 each; y_data  out  W;  y_ready  in  1: shared output.
REQ-008 s  out  1  current select: 0 = A, 1 = B.
REQ-009 busy  out  1  high while a grant is held.
REQ-010 timeout  out  1  one-cycle pulse on forced grant release.

Function
REQ-011 States: IDLE, GRANT_A, GRANT_B.
REQ-012 IDLE: y_valid=0, a_ready=0, b_ready=0, busy=0; s holds its last value.
REQ-013 Arbitration latency: 1 cycle; valid sampled in IDLE moves the FSM to a grant state on the next edge.
REQ-014 In IDLE, only a_valid -> GRANT_A; only b_valid -> GRANT_B; both -> the requester not in register last_served.
REQ-015 GRANT_A: s=0, y_valid/y_data/y_last = a_valid/a_data/a_last, a_ready=y_ready, b_ready=0. GRANT_B mirrors this with s=1.
REQ-016 Output paths are combinational through the mux; no data registering and zero added data latency.
REQ-017 Beat transfer = y_valid & y_ready; grant is held across beats until a transfer with y_last=1.
REQ-018 On a last-beat transfer: last_served <= granted requester; next state = other grant if other valid is high that cycle, else IDLE.
REQ-019 The requester's valid dropping mid-packet does not release the grant; the arbiter waits.
REQ-020 busy=1 in both grant states; s changes only on grant-state entry.

Reset
REQ-021 rst high forces immediately, independent of clk: state=IDLE, s=0, last_served=B (A wins the first tie), timeout=0, counter=0.
REQ-022 Reset mid-packet drops the grant with no completion; the requester resends the whole packet.

Configuration
REQ-023 With MUX2_RR_ARBITER_TIMEOUT_EN defined, a counter increments each grant-state cycle in which the granted valid=0, and clears on any transfer or grant change.
REQ-024 When the counter reaches TIMEOUT: timeout pulses for 1 cycle and the grant is released exactly as in REQ-018, with last_served updated.
REQ-025 Without the macro: no counter is built, timeout is tied 0, and grants release only per REQ-018.

Structure
REQ-026 Package mux2_arb_pkg holds the state encoding (IDLE=2'b00, GRANT_A=2'b01, GRANT_B=2'b10) and constants SEL_A=0, SEL_B=1.
REQ-027 The output datapath uses instances of the existing mux2x1 cell (one per y_data bit, plus y_valid and y_last), selected by s.

Verification
REQ-028 Only A sends a 3-beat packet 0x11,0x22,0x33 (last on 0x33), y_ready=1 -> grant after 1 cycle, s=0, y_data follows sequence, IDLE after third beat, b_ready=0 throughout.
REQ-029 A and B valid together out of reset -> A served first; on A's last beat FSM enters GRANT_B directly, s=1, no IDLE cycle.
REQ-030 y_ready=0 for 5 cycles mid-packet of B -> y_valid=1, b_ready=0, grant held, y_data stable, no timeout.
REQ-031 rst asserted during beat 2 of A's 4-beat packet -> outputs zero same cycle, state IDLE, s=0; after release A re-arbitrates and wins.
REQ-032 Macro on, TIMEOUT=4: A drops a_valid mid-packet while B valid -> after 4 idle cycles timeout=1 for one cycle, s=1, GRANT_B.
REQ-033 Macro off, same stimulus as REQ-032 -> timeout stays 0 and GRANT_A is held indefinitely.

Source files
------------

// File: rtl/mux2_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux2_arb_pkg : state encoding and select constants for mux2_rr_arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
package mux2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT_A = 2'b01,
    GRANT_B = 2'b10
  } arb_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mux2_rr_arbiter_datapath.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux2_rr_arbiter_datapath : bitwise mux2x1 output path, zeroed while no grant
// Revision 1.0
// ---------------------------------------------------------------------------
module mux2_rr_arbiter_datapath #(
  parameter int W = 8
) (
  input  logic         a_valid,
  input  logic         a_last,
  input  logic [W-1:0] a_data,
  input  logic         b_valid,
  input  logic         b_last,
  input  logic [W-1:0] b_data,
  input  logic         sel,
  input  logic         en,
  output logic         y_valid,
  output logic         y_last,
  output logic [W-1:0] y_data
);

  logic         mux_valid;
  logic         mux_last;
  logic [W-1:0] mux_data;

  generate
    for (genvar i = 0; i < W; i++) begin : g_data
      mux2x1 u_mux_data (
        .d0  (a_data[i]),
        .d1  (b_data[i]),
        .sel (sel),
        .y   (mux_data[i])
      );
    end
  endgenerate

  mux2x1 u_mux_valid (
    .d0  (a_valid),
    .d1  (b_valid),
    .sel (sel),
    .y   (mux_valid)
  );

  mux2x1 u_mux_last (
    .d0  (a_last),
    .d1  (b_last),
    .sel (sel),
    .y   (mux_last)
  );

  // s keeps its value in IDLE, so the mux alone would still leak a requester.
  assign y_valid = en & mux_valid;
  assign y_last  = en & mux_last;
  assign y_data  = en ? mux_data : '0;

endmodule
`default_nettype wire

// File: rtl/mux2x1.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux2x1 : single-bit 2:1 multiplexer cell (sel=0 -> d0, sel=1 -> d1)
// Revision 1.0
// ---------------------------------------------------------------------------
module mux2x1 (
  input  logic d0,
  input  logic d1,
  input  logic sel,
  output logic y
);

  assign y = sel ? d1 : d0;

endmodule
`default_nettype wire

// File: rtl/mux2_rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux2_rr_arbiter : packet-level round-robin arbiter for two requesters
// Optional idle-grant timeout enabled by MUX2_RR_ARBITER_TIMEOUT_EN.
// Revision 1.0
// ---------------------------------------------------------------------------
module mux2_rr_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int W       = 8,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_valid,
  input  logic         a_last,
  input  logic [W-1:0] a_data,
  output logic         a_ready,
  input  logic         b_valid,
  input  logic         b_last,
  input  logic [W-1:0] b_data,
  output logic         b_ready,
  output logic         y_valid,
  output logic         y_last,
  output logic [W-1:0] y_data,
  input  logic         y_ready,
  output logic         s,
  output logic         busy,
  output logic         timeout
);

  arb_state_t state;
  arb_state_t state_nxt;
  logic       s_nxt;
  logic       last_served;
  logic       last_served_nxt;
  logic       xfer;
  logic       release_grant;
  logic       timeout_hit;

  mux2_rr_arbiter_datapath #(
    .W (W)
  ) u_datapath (
    .a_valid (a_valid),
    .a_last  (a_last),
    .a_data  (a_data),
    .b_valid (b_valid),
    .b_last  (b_last),
    .b_data  (b_data),
    .sel     (s),
    .en      (busy),
    .y_valid (y_valid),
    .y_last  (y_last),
    .y_data  (y_data)
  );

  assign busy          = (state == GRANT_A) || (state == GRANT_B);
  assign a_ready       = (state == GRANT_A) && y_ready;
  assign b_ready       = (state == GRANT_B) && y_ready;
  assign xfer          = y_valid && y_ready;
  assign release_grant = (xfer && y_last) || timeout_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      s           <= SEL_A;
      last_served <= SEL_B;
    end else begin
      state       <= state_nxt;
      s           <= s_nxt;
      last_served <= last_served_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    s_nxt           = s;
    last_served_nxt = last_served;
    case (state)
      IDLE: begin
        if (a_valid && (!b_valid || (last_served == SEL_B))) begin
          state_nxt = GRANT_A;
          s_nxt     = SEL_A;
        end else if (b_valid) begin
          state_nxt = GRANT_B;
          s_nxt     = SEL_B;
        end
      end
      GRANT_A: begin
        if (release_grant) begin
          last_served_nxt = SEL_A;
          if (b_valid) begin
            state_nxt = GRANT_B;
            s_nxt     = SEL_B;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      GRANT_B: begin
        if (release_grant) begin
          last_served_nxt = SEL_B;
          if (a_valid) begin
            state_nxt = GRANT_A;
            s_nxt     = SEL_A;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef MUX2_RR_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] idle_cnt;
  logic [CW-1:0] idle_cnt_nxt;

  // While granted, y_valid equals the granted requester's valid.
  assign timeout_hit = busy && (idle_cnt == CW'(TIMEOUT));

  always_comb begin
    idle_cnt_nxt = idle_cnt;
    if (!busy || xfer || (state_nxt != state)) begin
      idle_cnt_nxt = '0;
    end else if (!y_valid) begin
      idle_cnt_nxt = idle_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt_nxt;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT != 0);
  assign timeout_hit        = 1'b0;
`endif

  assign timeout = timeout_hit;

endmodule
`default_nettype wire

// File: tb/tb_mux2_rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mux2_rr_arbiter : directed self-checking bench for mux2_rr_arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_mux2_rr_arbiter;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         a_valid, a_last, a_ready;
  logic [W-1:0] a_data;
  logic         b_valid, b_last, b_ready;
  logic [W-1:0] b_data;
  logic         y_valid, y_last, y_ready;
  logic [W-1:0] y_data;
  logic         s, busy, timeout;

  int n_checks;
  int n_fail;

  mux2_rr_arbiter #(
    .W       (W),
    .TIMEOUT (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .a_valid (a_valid),
    .a_last  (a_last),
    .a_data  (a_data),
    .a_ready (a_ready),
    .b_valid (b_valid),
    .b_last  (b_last),
    .b_data  (b_data),
    .b_ready (b_ready),
    .y_valid (y_valid),
    .y_last  (y_last),
    .y_data  (y_data),
    .y_ready (y_ready),
    .s       (s),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_a(input logic v, input logic l, input logic [W-1:0] d);
    a_valid = v; a_last = l; a_data = d;
  endtask

  task automatic drive_b(input logic v, input logic l, input logic [W-1:0] d);
    b_valid = v; b_last = l; b_data = d;
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    drive_a(1'b0, 1'b0, 8'h00);
    drive_b(1'b0, 1'b0, 8'h00);
    y_ready  = 1'b0;

    #3;
    check_eq("rst_s", s, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_y_valid", y_valid, 0);
    check_eq("rst_timeout", timeout, 0);
    check_eq("rst_a_ready", a_ready, 0);
    next_cycle();
    rst = 1'b0;

    // A alone: 3-beat packet 11,22,33
    next_cycle();
    drive_a(1'b1, 1'b0, 8'h11); y_ready = 1'b1; #1;
    check_eq("a3_idle_busy", busy, 0);
    check_eq("a3_idle_y_valid", y_valid, 0);
    check_eq("a3_idle_a_ready", a_ready, 0);
    next_cycle(); #1;
    check_eq("a3_b1_s", s, 0);
    check_eq("a3_b1_busy", busy, 1);
    check_eq("a3_b1_y_valid", y_valid, 1);
    check_eq("a3_b1_y_data", y_data, 8'h11);
    check_eq("a3_b1_a_ready", a_ready, 1);
    check_eq("a3_b1_b_ready", b_ready, 0);
    next_cycle();
    drive_a(1'b1, 1'b0, 8'h22); #1;
    check_eq("a3_b2_y_data", y_data, 8'h22);
    check_eq("a3_b2_b_ready", b_ready, 0);
    next_cycle();
    drive_a(1'b1, 1'b1, 8'h33); #1;
    check_eq("a3_b3_y_data", y_data, 8'h33);
    check_eq("a3_b3_y_last", y_last, 1);
    check_eq("a3_b3_b_ready", b_ready, 0);
    next_cycle();
    drive_a(1'b0, 1'b0, 8'h00); #1;
    check_eq("a3_end_busy", busy, 0);
    check_eq("a3_end_y_valid", y_valid, 0);
    check_eq("a3_end_s", s, 0);

    // Tie out of reset: A first, then straight into B
    pulse_reset();
    drive_a(1'b1, 1'b1, 8'hA1);
    drive_b(1'b1, 1'b0, 8'hB1); #1;
    check_eq("tie_idle_busy", busy, 0);
    next_cycle(); #1;
    check_eq("tie_a_s", s, 0);
    check_eq("tie_a_y_data", y_data, 8'hA1);
    check_eq("tie_a_a_ready", a_ready, 1);
    check_eq("tie_a_b_ready", b_ready, 0);
    next_cycle();
    drive_a(1'b0, 1'b0, 8'h00); y_ready = 1'b0; #1;
    check_eq("tie_b_busy", busy, 1);
    check_eq("tie_b_s", s, 1);
    check_eq("tie_b_y_data", y_data, 8'hB1);

    // Back-pressure on B for 5 cycles
    for (int i = 0; i < 5; i++) begin
      if (i != 0) begin
        next_cycle(); #1;
      end
      check_eq("bp_y_valid", y_valid, 1);
      check_eq("bp_b_ready", b_ready, 0);
      check_eq("bp_busy", busy, 1);
      check_eq("bp_y_data", y_data, 8'hB1);
      check_eq("bp_timeout", timeout, 0);
    end
    next_cycle();
    y_ready = 1'b1; #1;
    check_eq("bp_release_b_ready", b_ready, 1);
    check_eq("bp_release_y_data", y_data, 8'hB1);
    next_cycle();
    drive_b(1'b1, 1'b1, 8'hB2); #1;
    check_eq("b_last_y_data", y_data, 8'hB2);
    check_eq("b_last_y_last", y_last, 1);
    next_cycle();
    drive_b(1'b0, 1'b0, 8'h00); #1;
    check_eq("b_end_busy", busy, 0);
    check_eq("b_end_s_hold", s, 1);
    rst = 1'b1; #1;
    check_eq("async_rst_s", s, 0);
    next_cycle();
    rst = 1'b0;

    // Reset during beat 2 of a 4-beat A packet
    drive_a(1'b1, 1'b0, 8'h41); #1;
    check_eq("mr_idle_busy", busy, 0);
    next_cycle(); #1;
    check_eq("mr_b1_y_data", y_data, 8'h41);
    next_cycle();
    drive_a(1'b1, 1'b0, 8'h42); #1;
    check_eq("mr_b2_y_data", y_data, 8'h42);
    rst = 1'b1; #1;
    check_eq("mr_rst_y_valid", y_valid, 0);
    check_eq("mr_rst_y_data", y_data, 8'h00);
    check_eq("mr_rst_busy", busy, 0);
    check_eq("mr_rst_s", s, 0);
    check_eq("mr_rst_a_ready", a_ready, 0);
    next_cycle();
    rst = 1'b0;
    drive_a(1'b1, 1'b0, 8'h41); #1;
    check_eq("mr_rearb_busy", busy, 0);
    for (int i = 1; i <= 4; i++) begin
      next_cycle();
      drive_a(1'b1, (i == 4), 8'(8'h40 + i)); #1;
      check_eq("mr_resend_busy", busy, 1);
      check_eq("mr_resend_s", s, 0);
      check_eq("mr_resend_y_data", y_data, 32'(8'h40 + i));
    end
    next_cycle();
    drive_a(1'b0, 1'b0, 8'h00); #1;
    check_eq("mr_end_busy", busy, 0);

    // A stalls mid-packet while B waits
    pulse_reset();
    drive_a(1'b1, 1'b0, 8'h51); #1;
    next_cycle(); #1;
    check_eq("to_a_y_data", y_data, 8'h51);
    next_cycle();
    drive_a(1'b0, 1'b0, 8'h00);
    drive_b(1'b1, 1'b1, 8'h61); #1;
`ifdef MUX2_RR_ARBITER_TIMEOUT_EN
    for (int i = 1; i <= 5; i++) begin
      if (i != 1) begin
        next_cycle(); #1;
      end
      check_eq("to_idle_s", s, 0);
      check_eq("to_idle_busy", busy, 1);
      check_eq("to_pulse", timeout, (i == 5));
    end
    next_cycle(); #1;
    check_eq("to_after_s", s, 1);
    check_eq("to_after_timeout", timeout, 0);
    check_eq("to_after_y_data", y_data, 8'h61);
    check_eq("to_after_b_ready", b_ready, 1);
    next_cycle();
    drive_b(1'b0, 1'b0, 8'h00); #1;
    check_eq("to_end_busy", busy, 0);
`else
    for (int i = 0; i < 10; i++) begin
      if (i != 0) begin
        next_cycle(); #1;
      end
      check_eq("hold_timeout", timeout, 0);
      check_eq("hold_s", s, 0);
      check_eq("hold_busy", busy, 1);
      check_eq("hold_b_ready", b_ready, 0);
      check_eq("hold_y_valid", y_valid, 0);
    end
    next_cycle();
    drive_a(1'b1, 1'b1, 8'h52); #1;
    check_eq("hold_finish_y_data", y_data, 8'h52);
    next_cycle();
    drive_a(1'b0, 1'b0, 8'h00); #1;
    check_eq("hold_handoff_s", s, 1);
    check_eq("hold_handoff_y_data", y_data, 8'h61);
    next_cycle();
    drive_b(1'b0, 1'b0, 8'h00); #1;
    check_eq("hold_end_busy", busy, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
